// File: rtl/seg_scan_driver_if.sv
`default_nettype none
// ============================================================================
//  Module     : seg_scan_driver_if
//  Description: Display data bus between a character source (master) and
//               the 7-segment scan driver (slave). Six 4-bit character
//               codes, six decimal-point requests and a display enable.
//  Revision   : 1.0  initial release
// ============================================================================
interface seg_scan_driver_if;
    // [23:20] = digit 0 (leftmost) ... [3:0] = digit 5
    logic [23:0] data_in;
    // bit i requests the decimal point of digit i
    logic [5:0]  dp_in;
    // 1 = display on, 0 = all digits dark (scan keeps running)
    logic        en;

    modport master (
        output data_in,
        output dp_in,
        output en
    );

    modport slave (
        input  data_in,
        input  dp_in,
        input  en
    );
endinterface
`default_nettype wire

// File: rtl/seg_scan_driver.sv
`default_nettype none
// ============================================================================
//  Module     : seg_scan_driver
//  Description: Time-multiplexed driver for a 6-digit common-anode 7-segment
//               display. A frame of six character codes is captured into a
//               shadow register only at frame boundaries so the visible
//               content never tears. Each digit slot begins with a short
//               blank to suppress ghosting. All pin outputs are registered.
//  Revision   : 1.0  initial release
// ============================================================================
module seg_scan_driver #(
    parameter int SCAN_CNT  = 49_999,  // clk cycles per digit slot, minus 1
    parameter int BLANK_CYC = 500,     // blanked cycles at slot start, < SCAN_CNT
    parameter int CHAR_MODE = 0        // 0 = HELLO charset, 1 = hex charset
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    seg_scan_driver_if.slave  bus,
    output logic [5:0]        sel,
    output logic [7:0]        seg,
    output logic              frame_tick
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int CNT_W = (SCAN_CNT > 1) ? $clog2(SCAN_CNT + 1) : 1;

    localparam logic [CNT_W-1:0] C_CNT_MAX   = CNT_W'(SCAN_CNT);
    localparam logic [CNT_W-1:0] C_BLANK     = CNT_W'(BLANK_CYC);
    localparam logic [2:0]       C_IDX_LAST  = 3'd5;
    localparam logic [23:0]      C_DATA_RST  = 24'h555555;
    localparam logic [5:0]       C_DP_RST    = 6'h00;
    localparam logic [5:0]       C_SEL_OFF   = 6'h3F;
    localparam logic [7:0]       C_SEG_OFF   = 8'hFF;
    localparam logic [6:0]       C_GLYPH_OFF = 7'h7F;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [CNT_W-1:0] cnt_q,          cnt_d;
    logic [2:0]       idx_q,          idx_d;
    logic [23:0]      shadow_data_q,  shadow_data_d;
    logic [5:0]       shadow_dp_q,    shadow_dp_d;
    logic [5:0]       sel_q,          sel_d;
    logic [7:0]       seg_q,          seg_d;
    logic             frame_tick_q,   frame_tick_d;

    // Combinational helpers
    logic             w_slot_end;
    logic             w_frame_end;
    logic [3:0]       w_code;
    logic             w_dp;
    logic [6:0]       w_glyph;

    // ------------------------------------------------------------------------
    // Slot / frame boundary detection
    // ------------------------------------------------------------------------
    // A frame ends on the last cycle of the digit-5 slot.
    always_comb begin
        w_slot_end  = (cnt_q == C_CNT_MAX);
        w_frame_end = w_slot_end && (idx_q >= C_IDX_LAST);
    end

    // ------------------------------------------------------------------------
    // Scan counters: cnt sweeps one slot, idx steps through the six digits
    // ------------------------------------------------------------------------
    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        idx_d = idx_q;
        if (w_slot_end) begin
            cnt_d = '0;
            // >= keeps the scan self-recovering should idx ever leave 0..5
            idx_d = (idx_q >= C_IDX_LAST) ? 3'd0 : idx_q + 3'd1;
        end
    end

    // ------------------------------------------------------------------------
    // Shadow frame: reloaded only as idx wraps 5 -> 0, so every digit of a
    // displayed frame comes from the same snapshot of the bus
    // ------------------------------------------------------------------------
    always_comb begin
        shadow_data_d = shadow_data_q;
        shadow_dp_d   = shadow_dp_q;
        frame_tick_d  = 1'b0;
        if (w_frame_end) begin
            shadow_data_d = bus.data_in;
            shadow_dp_d   = bus.dp_in;
            frame_tick_d  = 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Pick the character code and dp request of the digit currently scanned
    // ------------------------------------------------------------------------
    always_comb begin
        w_code = 4'hF;
        w_dp   = 1'b0;
        case (idx_q)
            3'd0: begin w_code = shadow_data_q[23:20]; w_dp = shadow_dp_q[0]; end
            3'd1: begin w_code = shadow_data_q[19:16]; w_dp = shadow_dp_q[1]; end
            3'd2: begin w_code = shadow_data_q[15:12]; w_dp = shadow_dp_q[2]; end
            3'd3: begin w_code = shadow_data_q[11:8];  w_dp = shadow_dp_q[3]; end
            3'd4: begin w_code = shadow_data_q[7:4];   w_dp = shadow_dp_q[4]; end
            3'd5: begin w_code = shadow_data_q[3:0];   w_dp = shadow_dp_q[5]; end
            default: begin w_code = 4'hF; w_dp = 1'b0; end
        endcase
    end

    // ------------------------------------------------------------------------
    // Character decode, active-low segments {g,f,e,d,c,b,a}
    // ------------------------------------------------------------------------
    generate
        if (CHAR_MODE == 1) begin : g_hex
            // Hex digits 0-F
            always_comb begin
                w_glyph = C_GLYPH_OFF;
                case (w_code)
                    4'h0: w_glyph = 7'h40;
                    4'h1: w_glyph = 7'h79;
                    4'h2: w_glyph = 7'h24;
                    4'h3: w_glyph = 7'h30;
                    4'h4: w_glyph = 7'h19;
                    4'h5: w_glyph = 7'h12;
                    4'h6: w_glyph = 7'h02;
                    4'h7: w_glyph = 7'h78;
                    4'h8: w_glyph = 7'h00;
                    4'h9: w_glyph = 7'h10;
                    4'hA: w_glyph = 7'h08;
                    4'hB: w_glyph = 7'h03;
                    4'hC: w_glyph = 7'h46;
                    4'hD: w_glyph = 7'h21;
                    4'hE: w_glyph = 7'h06;
                    4'hF: w_glyph = 7'h0E;
                    default: w_glyph = C_GLYPH_OFF;
                endcase
            end
        end else begin : g_hello
            // H, E, L, L, O; every other code is a blank digit
            always_comb begin
                w_glyph = C_GLYPH_OFF;
                case (w_code)
                    4'h0: w_glyph = 7'h09;
                    4'h1: w_glyph = 7'h06;
                    4'h2: w_glyph = 7'h47;
                    4'h3: w_glyph = 7'h47;
                    4'h4: w_glyph = 7'h40;
                    default: w_glyph = C_GLYPH_OFF;
                endcase
            end
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Next pin values: dark when disabled, blank at slot start, else glyph.
    // The shift yields exactly one low sel bit (none for an invalid idx).
    // ------------------------------------------------------------------------
    always_comb begin
        sel_d = C_SEL_OFF;
        seg_d = C_SEG_OFF;
        if (bus.en) begin
            sel_d = ~(6'b00_0001 << idx_q);
            if (cnt_q >= C_BLANK) begin
                seg_d = {~w_dp, w_glyph};
            end
        end
    end

    // ------------------------------------------------------------------------
    // State and output registers; reset aborts any slot in progress
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q         <= '0;
            idx_q         <= 3'd0;
            shadow_data_q <= C_DATA_RST;
            shadow_dp_q   <= C_DP_RST;
            sel_q         <= C_SEL_OFF;
            seg_q         <= C_SEG_OFF;
            frame_tick_q  <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            shadow_data_q <= shadow_data_d;
            shadow_dp_q   <= shadow_dp_d;
            sel_q         <= sel_d;
            seg_q         <= seg_d;
            frame_tick_q  <= frame_tick_d;
        end
    end

    assign sel        = sel_q;
    assign seg        = seg_q;
    assign frame_tick = frame_tick_q;

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_driver.sv
`default_nettype none
// ============================================================================
//  Module     : tb_seg_scan_driver
//  Description: Self-checking bench for seg_scan_driver. Two instances (HELLO
//               and hex charsets) share clock and reset. Each frame's
//               expected sel/seg/frame_tick stream is queued up front and
//               popped one entry per clock as the DUT produces it.
//  Revision   : 1.0  initial release
// ============================================================================
module tb_seg_scan_driver;

    localparam int SCAN_CNT  = 9;
    localparam int BLANK_CYC = 2;
    localparam int SLOT      = SCAN_CNT + 1;
    localparam int FRAME     = 6 * SLOT;

    typedef struct {
        int               which;   // 0 = HELLO instance, 1 = hex instance
        logic [23:0]      data;
        logic [5:0]       dp;
        logic [0:5][7:0]  segs;    // expected seg per digit, after the blank
    } vec_t;

    typedef struct packed {
        logic [5:0] sel;
        logic [7:0] seg;
        logic       tick;
    } obs_t;

    logic clk;
    logic rst_n;
    logic [5:0] sel0, sel1;
    logic [7:0] seg0, seg1;
    logic       ft0, ft1;

    int   n_checks;
    int   n_pass;
    obs_t sb_q[$];
    vec_t vecs[7];

    seg_scan_driver_if bus0();
    seg_scan_driver_if bus1();

    seg_scan_driver #(.SCAN_CNT(SCAN_CNT), .BLANK_CYC(BLANK_CYC), .CHAR_MODE(0)) u_dut0 (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus0),
        .sel        (sel0),
        .seg        (seg0),
        .frame_tick (ft0)
    );

    seg_scan_driver #(.SCAN_CNT(SCAN_CNT), .BLANK_CYC(BLANK_CYC), .CHAR_MODE(1)) u_dut1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus1),
        .sel        (sel1),
        .seg        (seg1),
        .frame_tick (ft1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic set_data(input int which, input logic [23:0] d, input logic [5:0] p);
        if (which == 0) begin bus0.data_in = d; bus0.dp_in = p; end
        else            begin bus1.data_in = d; bus1.dp_in = p; end
    endtask

    task automatic set_en(input int which, input logic v);
        if (which == 0) bus0.en = v;
        else            bus1.en = v;
    endtask

    function automatic obs_t sample(input int which);
        obs_t o;
        if (which == 0) o = '{sel: sel0, seg: seg0, tick: ft0};
        else            o = '{sel: sel1, seg: seg1, tick: ft1};
        return o;
    endfunction

    // Wait (bounded) for the next frame_tick; n = negedges waited
    task automatic wait_tick(input int which, output int n);
        obs_t o;
        n = 0;
        for (int i = 1; i <= 2 * FRAME + 10; i++) begin
            @(negedge clk);
            o = sample(which);
            if (o.tick) begin
                n = i;
                return;
            end
        end
        n_checks++;
        $display("FAIL tick_timeout: got no frame_tick within %0d cycles (dut %0d)", 2 * FRAME + 10, which);
    endtask

    // Check one full frame starting the cycle after a frame_tick.
    // chg_at: step after which data_in is replaced (-1 = never).
    // en_at/en_len: step after which en is dropped, and for how many clocks.
    task automatic check_frame(input int which, input logic [0:5][7:0] e,
                               input int chg_at, input logic [23:0] chg_data,
                               input int en_at, input int en_len);
        obs_t x, a;
        for (int k = 1; k <= FRAME; k++) begin
            int  slot, c;
            logic dark;
            slot = (k - 1) / SLOT;
            c    = (k - 1) % SLOT;
            dark = (en_at > 0) && (k > en_at) && (k <= en_at + en_len);
            x.sel  = dark ? 6'h3F : ~(6'b00_0001 << slot);
            x.seg  = (dark || c < BLANK_CYC) ? 8'hFF : e[slot];
            x.tick = (k == FRAME);
            sb_q.push_back(x);
        end
        for (int k = 1; k <= FRAME; k++) begin
            @(negedge clk);
            a = sample(which);
            x = sb_q.pop_front();
            n_checks++;
            if (a == x) n_pass++;
            else $display("FAIL frame_step dut%0d k=%0d: got sel=%h seg=%h tick=%b expected sel=%h seg=%h tick=%b",
                          which, k, a.sel, a.seg, a.tick, x.sel, x.seg, x.tick);
            if (k == chg_at)          set_data(which, chg_data, 6'h00);
            if (k == en_at)           set_en(which, 1'b0);
            if (k == en_at + en_len)  set_en(which, 1'b1);
        end
    endtask

    initial begin
        int n;
        n_checks = 0;
        n_pass   = 0;

        vecs[0] = '{0, 24'h012345, 6'h00, {8'h89, 8'h86, 8'hC7, 8'hC7, 8'hC0, 8'hFF}};
        vecs[1] = '{0, 24'h444444, 6'h3F, {8'h40, 8'h40, 8'h40, 8'h40, 8'h40, 8'h40}};
        vecs[2] = '{0, 24'h56789A, 6'h21, {8'h7F, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h7F}};
        vecs[3] = '{0, 24'h210FED, 6'h00, {8'hC7, 8'h86, 8'h89, 8'hFF, 8'hFF, 8'hFF}};
        vecs[4] = '{1, 24'h0123AF, 6'h04, {8'hC0, 8'hF9, 8'h24, 8'hB0, 8'h88, 8'h8E}};
        vecs[5] = '{1, 24'h456789, 6'h00, {8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90}};
        vecs[6] = '{1, 24'hBCDE01, 6'h21, {8'h03, 8'hC6, 8'hA1, 8'h86, 8'hC0, 8'h79}};

        rst_n = 1'b0;
        set_data(0, 24'h012345, 6'h00);
        set_data(1, 24'h0123AF, 6'h04);
        bus0.en = 1'b1;
        bus1.en = 1'b1;

        // Reset state while the clock runs
        repeat (3) @(negedge clk);
        check("rst_sel0", int'(sel0), 'h3F);
        check("rst_seg0", int'(seg0), 'hFF);
        check("rst_tick0", int'(ft0), 0);
        check("rst_sel1", int'(sel1), 'h3F);
        check("rst_seg1", int'(seg1), 'hFF);
        check("rst_tick1", int'(ft1), 0);

        // First frame_tick 60 clocks after release
        rst_n = 1'b1;
        wait_tick(0, n);
        check("first_tick_latency", n, FRAME);
        check("first_tick_dut1", int'(ft1), 1);

        // Table of frames across both charsets
        for (int v = 0; v < 7; v++) begin
            set_data(vecs[v].which, vecs[v].data, vecs[v].dp);
            wait_tick(vecs[v].which, n);
            check("tick_period", n, FRAME);
            check_frame(vecs[v].which, vecs[v].segs, -1, 24'h0, -1, 0);
        end

        // No tearing: data changes in slot 2, visible only from next frame
        set_data(0, 24'h012345, 6'h00);
        wait_tick(0, n);
        check("tear_tick_period", n, FRAME);
        check_frame(0, {8'h89, 8'h86, 8'hC7, 8'hC7, 8'hC0, 8'hFF}, 25, 24'h444444, -1, 0);
        check_frame(0, {8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0}, -1, 24'h0, -1, 0);

        // Enable dropped for 15 clocks mid-slot; scan position unaffected
        check_frame(0, {8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0}, -1, 24'h0, 13, 15);

        // Reset during slot 3 goes dark at once; a blank frame then precedes data
        set_data(0, 24'h012345, 6'h00);
        repeat (35) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_sel0", int'(sel0), 'h3F);
        check("midrst_seg0", int'(seg0), 'hFF);
        check("midrst_tick0", int'(ft0), 0);
        check("midrst_sel1", int'(sel1), 'h3F);
        check("midrst_seg1", int'(seg1), 'hFF);
        @(negedge clk);
        rst_n = 1'b1;
        check_frame(0, {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF}, -1, 24'h0, -1, 0);
        check_frame(0, {8'h89, 8'h86, 8'hC7, 8'hC7, 8'hC0, 8'hFF}, -1, 24'h0, -1, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
